// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Load-use hazard detection and operand forwarding for the decode stage.
//   The unit tracks its own shadow copy of the in-flight writers (stage 1 = EX
//   .. stage FWD_STAGES = WB). Each decoded source is compared against that copy
//   to produce a per-source forward select and a load-use stall request. A
//   saturating counter accumulates the number of stall cycles.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   id_valid     decode stage holds a valid instruction
//   id_src_addr  packed source addresses, source i at [i*REG_AW +: REG_AW]
//   id_src_used  per-source "actually read" flags
//   id_rd        destination register of the decoded instruction
//   id_regwr     decoded instruction writes the register file
//   id_memrd     decoded instruction is a load
//   flush        kill the decode-stage instruction (not inserted)
//   hold         freeze shadow pipeline and stall counter
//   stat_clr     synchronous clear of stall_count
//   stall        load-use stall request to decode/fetch
//   fwd_sel      per-source select, 0 = register file, k = stage k
//   stall_count  saturating count of stall cycles
module hazard_forward_unit #(
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 3,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwr,
    input  logic                      id_memrd,
    input  logic                      flush,
    input  logic                      hold,
    input  logic                      stat_clr,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic [CNT_W-1:0]          stall_count
);

    // Shadow pipeline; array index j holds stage j+1.
    logic [FWD_STAGES-1:0] sh_v;
    logic [FWD_STAGES-1:0] sh_ld;
    logic [REG_AW-1:0]     sh_rd [FWD_STAGES];

    logic [NUM_SRC-1:0]    hit;
    logic [NUM_SRC-1:0]    hazard;
    logic [SEL_W-1:0]      k_sel [NUM_SRC];
    logic                  insert;

    // A stalled instruction stays in decode, so it must not enter stage 1 yet.
    assign insert = id_valid & id_regwr & ~stall & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_v  <= '0;
            sh_ld <= '0;
            for (int j = 0; j < FWD_STAGES; j++) begin
                sh_rd[j] <= '0;
            end
        end else if (!hold) begin
            sh_v[0]  <= insert;
            sh_ld[0] <= insert & id_memrd;
            sh_rd[0] <= id_rd;
            for (int j = 1; j < FWD_STAGES; j++) begin
                sh_v[j]  <= sh_v[j-1];
                sh_ld[j] <= sh_ld[j-1];
                sh_rd[j] <= sh_rd[j-1];
            end
        end
    end

    // Scan oldest to youngest so the youngest match is the one that sticks;
    // this lets a younger ALU result mask an older load and vice versa.
    always_comb begin
        hit    = '0;
        hazard = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            k_sel[i] = '0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = FWD_STAGES - 1; j >= 0; j--) begin
                if (id_src_used[i] && sh_v[j] &&
                    (sh_rd[j] == id_src_addr[i*REG_AW +: REG_AW]) &&
                    (ZERO_REG == 0 || id_src_addr[i*REG_AW +: REG_AW] != '0)) begin
                    hit[i]    = 1'b1;
                    hazard[i] = sh_ld[j] && ((j + 1) <= LOAD_LAT);
                    k_sel[i]  = SEL_W'(j + 1);
                end
            end
        end
    end

    assign stall = id_valid & ~flush & (|hazard);

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_valid && !stall && hit[i]) begin
                fwd_sel[i*SEL_W +: SEL_W] = k_sel[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stat_clr) begin
            stall_count <= '0;
        end else if (stall && !hold && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [5:0] id_src_addr;
    logic [1:0] id_src_used;
    logic [2:0] id_rd;
    logic       id_regwr;
    logic       id_memrd;
    logic       flush;
    logic       hold;
    logic       stat_clr;
    logic       stall;
    logic [3:0] fwd_sel;
    logic [15:0] stall_count;
    logic       stall_s;
    logic [3:0] fwd_sel_s;
    logic [1:0] stall_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwr(id_regwr),
        .id_memrd(id_memrd), .flush(flush), .hold(hold), .stat_clr(stat_clr),
        .stall(stall), .fwd_sel(fwd_sel), .stall_count(stall_count)
    );

    // Same stimulus, narrow counter for the saturation check.
    hazard_forward_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_regwr(id_regwr),
        .id_memrd(id_memrd), .flush(flush), .hold(hold), .stat_clr(stat_clr),
        .stall(stall_s), .fwd_sel(fwd_sel_s), .stall_count(stall_count_s)
    );

    task automatic drive(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [1:0] used, input logic [2:0] rd,
                         input logic wr, input logic ld);
        id_valid    = v;
        id_src_addr = {s1, s0};
        id_src_used = used;
        id_rd       = rd;
        id_regwr    = wr;
        id_memrd    = ld;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 0; hold = 0; stat_clr = 0;
        drive(1, 3'd3, 3'd4, 2'b11, 3'd0, 0, 0);
        @(negedge clk); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0d exp 0", stall); end
        checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL rst_fwd got %0h exp 0", fwd_sel); end
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall2 got %0d exp 0", stall); end
        checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL rst_fwd2 got %0h exp 0", fwd_sel); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", stall_count); end
        checks++; if (stall_count_s !== 2'd0) begin errors++; $display("FAIL rst_cnt_sat got %0d exp 0", stall_count_s); end
    endtask

    task automatic test_forward;
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd3, 1, 0); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_add_stall got %0d exp 0", stall); end
        @(negedge clk); drive(1, 3'd3, 3'd0, 2'b01, 3'd0, 0, 0); #1;
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL fwd_stage1 got %0h exp 1", fwd_sel); end
        @(negedge clk); #1;
        checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL fwd_stage2 got %0h exp 2", fwd_sel); end
        @(negedge clk); #1;
        checks++; if (fwd_sel !== 4'b0011) begin errors++; $display("FAIL fwd_stage3 got %0h exp 3", fwd_sel); end
        @(negedge clk); #1;
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL fwd_retired got %0h exp 0", fwd_sel); end
    endtask

    task automatic test_load_use;
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd5, 1, 1); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_lw_stall got %0d exp 0", stall); end
        @(negedge clk); drive(1, 3'd0, 3'd5, 2'b10, 3'd0, 0, 0); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0d exp 1", stall); end
        checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL lu_fwd_stalled got %0h exp 0", fwd_sel); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL lu_cnt0 got %0d exp 0", stall_count); end
        @(negedge clk); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %0d exp 0", stall); end
        checks++; if (fwd_sel !== 4'b1000) begin errors++; $display("FAIL lu_fwd2 got %0h exp 8", fwd_sel); end
        checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_cnt1 got %0d exp 1", stall_count); end
        checks++; if (stall_count_s !== 2'd1) begin errors++; $display("FAIL lu_cnt1_sat got %0d exp 1", stall_count_s); end
    endtask

    task automatic test_youngest;
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd2, 1, 0);
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd2, 1, 1);
        @(negedge clk); drive(1, 3'd2, 3'd0, 2'b01, 3'd0, 0, 0); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL yng_load_stall got %0d exp 1", stall); end
        checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL yng_load_fwd got %0h exp 0", fwd_sel); end
        drive(0, 3'd0, 3'd0, 2'b00, 3'd0, 0, 0);
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd2, 1, 1);
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd2, 1, 0);
        @(negedge clk); drive(1, 3'd2, 3'd0, 2'b01, 3'd0, 0, 0); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL yng_mask_stall got %0d exp 0", stall); end
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL yng_mask_fwd got %0h exp 1", fwd_sel); end
    endtask

    task automatic test_zero_reg;
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd0, 1, 1);
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b11, 3'd0, 0, 0); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %0d exp 0", stall); end
        checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL zero_fwd got %0h exp 0", fwd_sel); end
    endtask

    task automatic test_hold;
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd6, 1, 1);
        @(negedge clk); drive(1, 3'd6, 3'd0, 2'b01, 3'd0, 0, 0); hold = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall0 got %0d exp 1", stall); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall cyc %0d got %0d exp 1", c, stall); end
            checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL hold_cnt cyc %0d got %0d exp 1", c, stall_count); end
        end
        hold = 1'b0;
        @(negedge clk); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_release got %0d exp 0", stall); end
        checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL hold_fwd2 got %0h exp 2", fwd_sel); end
        checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL hold_cnt2 got %0d exp 2", stall_count); end
    endtask

    task automatic test_flush;
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd7, 1, 0); flush = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %0d exp 0", stall); end
        @(negedge clk); flush = 1'b0; drive(1, 3'd7, 3'd0, 2'b01, 3'd0, 0, 0); #1;
        checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL flush_fwd got %0h exp 0", fwd_sel); end
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd1, 1, 1);
        @(negedge clk); drive(1, 3'd1, 3'd0, 2'b01, 3'd0, 0, 0); flush = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_lu_stall got %0d exp 0", stall); end
        @(negedge clk); flush = 1'b0; drive(0, 3'd0, 3'd0, 2'b00, 3'd0, 0, 0); #1;
        checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL flush_cnt got %0d exp 2", stall_count); end
    endtask

    task automatic test_saturation;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd4, 1, 1);
            @(negedge clk); drive(1, 3'd4, 3'd0, 2'b01, 3'd0, 0, 0);
            @(negedge clk); drive(0, 3'd0, 3'd0, 2'b00, 3'd0, 0, 0);
        end
        #1;
        checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL sat_cnt_wide got %0d exp 5", stall_count); end
        checks++; if (stall_count_s !== 2'd3) begin errors++; $display("FAIL sat_cnt_narrow got %0d exp 3", stall_count_s); end
        @(negedge clk); drive(1, 3'd0, 3'd0, 2'b00, 3'd4, 1, 1);
        @(negedge clk); drive(1, 3'd4, 3'd0, 2'b01, 3'd0, 0, 0); stat_clr = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL clr_stall got %0d exp 1", stall); end
        @(negedge clk); stat_clr = 1'b0; drive(0, 3'd0, 3'd0, 2'b00, 3'd0, 0, 0); #1;
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL clr_cnt_wide got %0d exp 0", stall_count); end
        checks++; if (stall_count_s !== 2'd0) begin errors++; $display("FAIL clr_cnt_narrow got %0d exp 0", stall_count_s); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_youngest();
        test_zero_reg();
        test_hold();
        test_flush();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
